// File: rtl/synth_pkg.sv
// Shared FSM state and default widths
// for the wavetable reader slice.
package synth_pkg;

  localparam int ADDRWIDTH_DEF  = 12;
  localparam int WIDTH_DEF      = 16;
  localparam int PHASEWIDTH_DEF = 24;

  typedef enum logic [2:0] {
    IDLE,
    ADDR1,
    CAP0,
    CAP1,
    INTERP
  } state_e;

endpackage

// File: rtl/wt_lerp.sv
// Linear interpolation between two adjacent
// signed table samples by a fractional phase.
module wt_lerp #(
  parameter int WIDTH = 16,
  parameter int FRACW = 12
) (
  input  logic signed [WIDTH-1:0] d0,
  input  logic signed [WIDTH-1:0] d1,
  input  logic        [FRACW-1:0] frac,
  output logic signed [WIDTH-1:0] sample
);

  localparam int PW = WIDTH + FRACW + 2;

  logic signed [WIDTH:0] diff;
  logic signed [PW-1:0]  diff_x;
  logic signed [PW-1:0]  frac_x;
  logic signed [PW-1:0]  prod;

  always_comb begin
    diff   = {d1[WIDTH-1], d1} - {d0[WIDTH-1], d0};
    diff_x = {{(PW-WIDTH-1){diff[WIDTH]}}, diff};
    frac_x = {{(PW-FRACW){1'b0}}, frac};
    prod   = diff_x * frac_x;
    // floor of the scaled step keeps the result between d0 and d1
    sample = d0 + WIDTH'(prod >>> FRACW);
  end

endmodule

// File: rtl/wavetable_reader.sv
// Phase-accumulating wavetable reader with
// two-tap sync-ROM fetch and interpolation.
module wavetable_reader
  import synth_pkg::*;
#(
  parameter int ADDRWIDTH  = ADDRWIDTH_DEF,
  parameter int WIDTH      = WIDTH_DEF,
  parameter int PHASEWIDTH = PHASEWIDTH_DEF
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  sample_tick,
  input  logic [PHASEWIDTH-1:0] freq_word,
  input  logic                  phase_reset,
  output logic [ADDRWIDTH-1:0]  rom_addr,
  input  logic [WIDTH-1:0]      rom_data,
  output logic [WIDTH-1:0]      sample_out,
  output logic                  sample_valid,
  output logic                  busy,
  output logic                  overrun
);

  localparam int FRACW = PHASEWIDTH - ADDRWIDTH;

  state_e state_q, state_d;

  logic [PHASEWIDTH-1:0] phase_q, phase_d;
  logic [PHASEWIDTH-1:0] look;
  logic [ADDRWIDTH-1:0]  rom_addr_q, rom_addr_d;
  logic [FRACW-1:0]      frac_q, frac_d;
  logic [WIDTH-1:0]      d0_q, d0_d;
  logic [WIDTH-1:0]      d1_q, d1_d;
  logic [WIDTH-1:0]      sample_q, sample_d;
  logic [WIDTH-1:0]      lerp_out;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;

  wt_lerp #(
    .WIDTH (WIDTH),
    .FRACW (FRACW)
  ) u_lerp (
    .d0     (d0_q),
    .d1     (d1_q),
    .frac   (frac_q),
    .sample (lerp_out)
  );

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    rom_addr_d = rom_addr_q;
    frac_d     = frac_q;
    d0_d       = d0_q;
    d1_d       = d1_q;
    sample_d   = sample_q;
    valid_d    = 1'b0;
    overrun_d  = overrun_q;
    look       = phase_reset ? '0 : phase_q;

    if (phase_reset) phase_d = '0;

    unique case (state_q)
      IDLE: begin
        if (sample_tick) begin
          rom_addr_d = look[PHASEWIDTH-1 -: ADDRWIDTH];
          frac_d     = look[FRACW-1:0];
          phase_d    = look + freq_word;
          state_d    = ADDR1;
        end
      end
      ADDR1: begin
        rom_addr_d = rom_addr_q + ADDRWIDTH'(1);
        state_d    = CAP0;
      end
      CAP0: begin
        d0_d    = rom_data;
        state_d = CAP1;
      end
      CAP1: begin
        d1_d    = rom_data;
        state_d = INTERP;
      end
      INTERP: begin
        sample_d = lerp_out;
        valid_d  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (sample_tick && state_q != IDLE) overrun_d = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      rom_addr_q <= '0;
      frac_q     <= '0;
      d0_q       <= '0;
      d1_q       <= '0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      rom_addr_q <= rom_addr_d;
      frac_q     <= frac_d;
      d0_q       <= d0_d;
      d1_q       <= d1_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rom_addr     = rom_addr_q;
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign busy         = (state_q != IDLE);
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_wavetable_reader.sv
// Directed bench for wavetable_reader with
// a behavioural synchronous ROM model.
module tb_wavetable_reader;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        sample_tick;
  logic [23:0] freq_word;
  logic        phase_reset;
  logic [11:0] rom_addr;
  logic [15:0] rom_data;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        busy;
  logic        overrun;

  logic [15:0] mem [4096];

  int errors = 0;
  int checks = 0;
  int vcnt;

  typedef struct {
    logic [23:0] f;
    logic        pr;
    logic [11:0] a0;
    logic [11:0] a1;
    logic [15:0] s;
  } vec_t;

  vec_t vecs [6];

  wavetable_reader dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .sample_tick  (sample_tick),
    .freq_word    (freq_word),
    .phase_reset  (phase_reset),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) rom_data <= mem[rom_addr];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Caller is 1 time unit past an edge with the FSM idle.
  task automatic do_sample(input string nm,
                           input logic [23:0] f,
                           input logic pr,
                           input logic [11:0] a0,
                           input logic [11:0] a1,
                           input logic [15:0] s);
    int n;
    n = 0;
    sample_tick = 1'b1;
    freq_word   = f;
    phase_reset = pr;
    step();
    sample_tick = 1'b0;
    phase_reset = 1'b0;
    chk({nm, ".addr0"}, 32'(rom_addr), 32'(a0));
    chk({nm, ".busy"}, 32'(busy), 32'd1);
    if (sample_valid) n++;
    step();
    chk({nm, ".addr1"}, 32'(rom_addr), 32'(a1));
    for (int k = 2; k < 5; k++) begin
      if (sample_valid) n++;
      step();
    end
    chk({nm, ".early_valid"}, 32'(n), 32'd0);
    chk({nm, ".valid"}, 32'(sample_valid), 32'd1);
    chk({nm, ".sample"}, 32'(sample_out), 32'(s));
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'(i * 4);

    vecs[0] = '{24'h001000, 1'b0, 12'h000, 12'h001, 16'h0000};
    vecs[1] = '{24'h001000, 1'b0, 12'h001, 12'h002, 16'h0004};
    vecs[2] = '{24'h000800, 1'b0, 12'h002, 12'h003, 16'h0008};
    vecs[3] = '{24'h000100, 1'b0, 12'h002, 12'h003, 16'h000A};
    vecs[4] = '{24'h000400, 1'b1, 12'h000, 12'h001, 16'h0000};
    vecs[5] = '{24'h000000, 1'b0, 12'h000, 12'h001, 16'h0001};

    Reset       = 1'b1;
    sample_tick = 1'b0;
    freq_word   = '0;
    phase_reset = 1'b0;
    step();
    step();
    Reset = 1'b0;
    chk("rst.addr", 32'(rom_addr), 32'd0);
    chk("rst.sample", 32'(sample_out), 32'd0);
    chk("rst.valid", 32'(sample_valid), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.overrun", 32'(overrun), 32'd0);

    for (int i = 0; i < 6; i++)
      do_sample($sformatf("vec%0d", i), vecs[i].f, vecs[i].pr,
                vecs[i].a0, vecs[i].a1, vecs[i].s);

    // interpolation at half-step, both slopes
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    mem[0] = 16'h0100;
    mem[1] = 16'h0200;
    do_sample("lerp_pre", 24'h000800, 1'b0, 12'h000, 12'h001, 16'h0100);
    do_sample("lerp_pos", 24'h000000, 1'b0, 12'h000, 12'h001, 16'h0180);
    mem[0] = 16'h0200;
    mem[1] = 16'h0100;
    do_sample("lerp_neg", 24'h000000, 1'b0, 12'h000, 12'h001, 16'h0180);
    mem[0] = 16'h0000;
    mem[1] = 16'h0004;

    // index and phase wrap
    do_sample("wrap_set", 24'hFFF000, 1'b1, 12'h000, 12'h001, 16'h0000);
    do_sample("wrap_idx", 24'h000FFF, 1'b0, 12'hFFF, 12'h000, 16'h3FFC);
    do_sample("wrap_frac", 24'h000001, 1'b0, 12'hFFF, 12'h000, 16'h0003);
    do_sample("wrap_zero", 24'h000000, 1'b0, 12'h000, 12'h001, 16'h0000);

    // phase_reset with tick from a non-zero phase
    do_sample("pr_set", 24'h123456, 1'b1, 12'h000, 12'h001, 16'h0000);
    do_sample("pr_tick", 24'h000800, 1'b1, 12'h000, 12'h001, 16'h0000);
    do_sample("pr_after", 24'h000000, 1'b0, 12'h000, 12'h001, 16'h0002);

    // dropped tick at T+2, accepted tick at T+5
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("ovr.clear", 32'(overrun), 32'd0);
    vcnt        = 0;
    sample_tick = 1'b1;
    freq_word   = 24'h001000;
    step();
    for (int k = 1; k <= 5; k++) begin
      sample_tick = (k == 2) || (k == 5);
      freq_word   = 24'h001000;
      if (sample_valid) vcnt++;
      if (k == 3) chk("ovr.set", 32'(overrun), 32'd1);
      if (k == 5) chk("ovr.sample0", 32'(sample_out), 32'd0);
      step();
    end
    sample_tick = 1'b0;
    chk("ovr.accept", 32'(busy), 32'd1);
    chk("ovr.addr", 32'(rom_addr), 32'd1);
    for (int k = 6; k < 10; k++) begin
      if (sample_valid) vcnt++;
      step();
    end
    chk("ovr.one_valid", 32'(vcnt), 32'd1);
    chk("ovr.valid2", 32'(sample_valid), 32'd1);
    chk("ovr.sample1", 32'(sample_out), 32'd4);
    chk("ovr.sticky", 32'(overrun), 32'd1);

    // reset at T+3 aborts the sample
    step();
    sample_tick = 1'b1;
    freq_word   = 24'h001000;
    step();
    sample_tick = 1'b0;
    step();
    step();
    Reset       = 1'b1;
    sample_tick = 1'b1;
    phase_reset = 1'b1;
    step();
    Reset       = 1'b0;
    sample_tick = 1'b0;
    phase_reset = 1'b0;
    chk("rmid.addr", 32'(rom_addr), 32'd0);
    chk("rmid.sample", 32'(sample_out), 32'd0);
    chk("rmid.valid", 32'(sample_valid), 32'd0);
    chk("rmid.busy", 32'(busy), 32'd0);
    chk("rmid.overrun", 32'(overrun), 32'd0);
    vcnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (sample_valid) vcnt++;
      step();
    end
    chk("rmid.no_valid", 32'(vcnt), 32'd0);
    do_sample("rmid.after", 24'h001000, 1'b0, 12'h000, 12'h001, 16'h0000);
    do_sample("rmid.next", 24'h001000, 1'b0, 12'h001, 12'h002, 16'h0004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wavetable_reader.md
WAVETABLE_READER -- requirements
Module: wavetable_reader

Interface
REQ-001 SHALL have parameter ADDRWIDTH, default 12, meaning table address bits (4096 entries).
REQ-002 SHALL have parameter WIDTH, default 16, meaning signed sample width.
REQ-003 SHALL have parameter PHASEWIDTH, default 24, meaning phase accumulator bits; FRACW = PHASEWIDTH-ADDRWIDTH.
REQ-004 SHALL have port Clk  input  1  the single clock; all logic on rising edge.
REQ-005 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port sample_tick  input  1  one-cycle request for the next sample.
REQ-007 SHALL have port freq_word  input  PHASEWIDTH  phase increment, sampled on an accepted tick.
REQ-008 SHALL have port phase_reset  input  1  forces the accumulator to zero.
REQ-009 SHALL have port rom_addr  output  ADDRWIDTH  registered table address to the synchronous ROM.
REQ-010 SHALL have port rom_data  input  WIDTH  ROM read data, valid one cycle after rom_addr.
REQ-011 SHALL have port sample_out  output  WIDTH  signed interpolated sample, held until the next result.
REQ-012 SHALL have port sample_valid  output  1  one-cycle pulse when sample_out updates.
REQ-013 SHALL have port busy  output  1  high whenever the FSM is not IDLE.
REQ-014 SHALL have port overrun  output  1  sticky flag for a tick dropped while busy.

Function
REQ-015 SHALL implement FSM states IDLE, ADDR1, CAP0, CAP1, INTERP; IDLE->ADDR1 on tick, then one state per cycle, INTERP->IDLE.
REQ-016 SHALL, on a tick in IDLE (cycle T), register rom_addr <= phase[PHASEWIDTH-1 -: ADDRWIDTH], latch frac = phase[FRACW-1:0], and update phase <= phase + freq_word (modulo 2^PHASEWIDTH).
REQ-017 SHALL, in ADDR1 (T+1), register rom_addr <= index+1 modulo 2^ADDRWIDTH (index all-ones wraps to 0).
REQ-018 SHALL capture d0 = rom_data at the end of CAP0 (T+2) and d1 = rom_data at the end of CAP1 (T+3).
REQ-019 SHALL compute in INTERP (T+4): sample = d0 + ((d1-d0)*frac) >>> FRACW, with a signed WIDTH+1-bit difference, a full-width product, and an arithmetic shift; the result always fits in WIDTH bits.
REQ-020 SHALL present sample_out and pulse sample_valid in cycle T+5, giving a fixed latency of 5 cycles from tick to valid.
REQ-021 SHALL drop a tick that arrives while busy, set overrun, and leave phase unchanged.
REQ-022 SHALL, when phase_reset and an accepted tick occur together, use phase 0 for the lookup and set phase <= freq_word.
REQ-023 SHALL, on phase_reset without a tick, set phase <= 0 at any state; an in-flight sample completes using the frac already latched.
REQ-024 SHALL accept a tick in the cycle busy falls, so back-to-back samples are 5 cycles apart.

Reset
REQ-025 SHALL, on Reset, set state=IDLE, phase=0, rom_addr=0, sample_out=0, sample_valid=0, busy=0, overrun=0, d0=d1=frac=0.
REQ-026 SHALL, when Reset is asserted mid-operation, abort the sample with no sample_valid pulse, and Reset SHALL dominate both tick and phase_reset.

Structure
REQ-027 SHALL place the FSM state enum and default width constants in shared package synth_pkg.
REQ-028 SHALL implement the REQ-019 arithmetic in one combinational sub-module, wt_lerp (inputs d0, d1, frac; output sample).

Verification
REQ-029 SHALL test: Reset, then freq_word=0x001000, tick; ROM mem[i]=i*4 -> rom_addr 0 then 1, sample_out=0x0000 valid at T+5; next tick reads index 1.
REQ-030 SHALL test interpolation: phase=0x000800, d0=0x0100, d1=0x0200 -> sample_out=0x0180; with d0=0x0200, d1=0x0100 -> 0x0180 (negative slope).
REQ-031 SHALL test wrap: phase index 0xFFF -> rom_addr 0xFFF then 0x000; phase 0xFFFFFF + 1 wraps to 0x000000.
REQ-032 SHALL test a tick at T+2 while busy -> ignored, overrun=1 sticky, exactly one sample_valid; a tick at T+5 is accepted.
REQ-033 SHALL test phase_reset together with a tick at phase 0x123456 -> lookup uses index 0, phase becomes freq_word.
REQ-034 SHALL test Reset asserted at T+3 -> no sample_valid, all outputs 0 the next cycle, and a following tick operates normally.
